// File: rtl/char_deserializer.sv
// Serial frame receiver (start, DATA_W data bits MSB first, parity, stop) feeding the character decoder.
// Define CHAR_FILTER_EN to deliver only the eight valid decoder codes and flag others on code_err.
module char_deserializer #(
   parameter int DATA_W     = 7,
   parameter int PARITY_ODD = 1
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              bit_en,
   input  logic              serial_in,
   output logic [DATA_W-1:0] Entrada,
   output logic              Controle,
   output logic              parity_err,
   output logic              frame_err,
`ifdef CHAR_FILTER_EN
   output logic              code_err,
`endif
   output logic              busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DATA   = 3'd1;
   localparam logic [2:0] ST_PARITY = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
   localparam logic [2:0] ST_BREAK  = 3'd4;

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   function automatic logic parity_ok(input logic [DATA_W-1:0] data, input logic par);
      return ((^data) ^ par) == 1'(PARITY_ODD);
   endfunction

`ifdef CHAR_FILTER_EN
   function automatic logic is_valid_code(input logic [DATA_W-1:0] data);
      logic valid;
      case (data)
         7'b1100000, 7'b1000100, 7'b1111100, 7'b1011010,
         7'b1101110, 7'b1001001, 7'b1110101, 7'b1010011: valid = 1'b1;
         default:                                         valid = 1'b0;
      endcase
      return valid;
   endfunction
`endif

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [DATA_W-1:0] entrada_q, entrada_d;
   logic              controle_q, controle_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q, frame_err_d;
   logic              code_err_q, code_err_d;
   logic              par_good_s;

   assign par_good_s = parity_ok(shift_q, par_q);

   // Next-state logic: everything advances only on bit_en; pulses default low every clock.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      entrada_d    = entrada_q;
      controle_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      code_err_d   = 1'b0;
      if (bit_en) begin
         case (state_q)
            ST_IDLE: begin
               if (!serial_in) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_d   = {shift_q[DATA_W-2:0], serial_in};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == LAST_CNT) begin
                  state_d = ST_PARITY;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_PARITY: begin
               par_d   = serial_in;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               if (serial_in) begin
                  state_d = ST_IDLE;
                  if (par_good_s) begin
`ifdef CHAR_FILTER_EN
                     if (is_valid_code(shift_q)) begin
                        entrada_d  = shift_q;
                        controle_d = 1'b1;
                     end else begin
                        code_err_d = 1'b1;
                     end
`else
                     entrada_d  = shift_q;
                     controle_d = 1'b1;
`endif
                  end else begin
                     parity_err_d = 1'b1;
                  end
               end else begin
                  // A low stop bit means the line may be held in break; wait for it to rise.
                  state_d      = ST_BREAK;
                  frame_err_d  = 1'b1;
                  parity_err_d = !par_good_s;
               end
            end
            ST_BREAK: begin
               if (serial_in) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BREAK;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         entrada_q    <= '0;
         controle_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         code_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         entrada_q    <= entrada_d;
         controle_q   <= controle_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         code_err_q   <= code_err_d;
      end
   end

   assign Entrada    = entrada_q;
   assign Controle   = controle_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != ST_IDLE);
`ifdef CHAR_FILTER_EN
   assign code_err   = code_err_q;
`else
   logic unused_code_err_s;
   assign unused_code_err_s = code_err_q;
`endif

endmodule

// File: tb/tb_char_deserializer.sv
// Scoreboard bench for char_deserializer: expected pulses are queued as each stop bit is driven.
module tb_char_deserializer;

   logic       clk = 1'b0;
   logic       Reset;
   logic       bit_en;
   logic       serial_in;
   logic [6:0] Entrada;
   logic       Controle;
   logic       parity_err;
   logic       frame_err;
   logic       code_err;
   logic       busy;

   always #5 clk = ~clk;

   char_deserializer #(.DATA_W(7), .PARITY_ODD(1)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .bit_en     (bit_en),
      .serial_in  (serial_in),
      .Entrada    (Entrada),
      .Controle   (Controle),
      .parity_err (parity_err),
      .frame_err  (frame_err),
`ifdef CHAR_FILTER_EN
      .code_err   (code_err),
`endif
      .busy       (busy)
   );

`ifdef CHAR_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
   assign code_err = 1'b0;
`endif

   typedef struct {
      logic       c;
      logic       pe;
      logic       fe;
      logic       ce;
      logic [6:0] data;
      int         due;
   } exp_t;

   exp_t       sb[$];
   int         compared   = 0;
   int         mismatched = 0;
   int         cyc        = 0;
   logic [6:0] model_entrada = 7'd0;
   logic [6:0] prev_entrada  = 7'd0;

   function automatic logic model_code_ok(input logic [6:0] d);
      return !FILTER ||
             (d == 7'b1100000) || (d == 7'b1000100) || (d == 7'b1111100) || (d == 7'b1011010) ||
             (d == 7'b1101110) || (d == 7'b1001001) || (d == 7'b1110101) || (d == 7'b1010011);
   endfunction

   // One clock: observe at the falling edge and retire any pulse against the scoreboard.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      compared++;
      if (Entrada !== prev_entrada && Controle !== 1'b1) begin
         mismatched++;
         $display("FAIL entrada_stable: Entrada=%b changed from %b without Controle (cycle %0d)",
                  Entrada, prev_entrada, cyc);
      end
      prev_entrada = Entrada;
      if (Controle === 1'b1 || parity_err === 1'b1 || frame_err === 1'b1 || code_err === 1'b1) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_pulse: C=%b PE=%b FE=%b CE=%b at cycle %0d, required none",
                     Controle, parity_err, frame_err, code_err, cyc);
         end else begin
            e = sb.pop_front();
            if ({Controle, parity_err, frame_err, code_err} !== {e.c, e.pe, e.fe, e.ce} ||
                Entrada !== e.data || cyc != e.due) begin
               mismatched++;
               $display("FAIL pulse: got C=%b PE=%b FE=%b CE=%b Entrada=%b cycle %0d, required C=%b PE=%b FE=%b CE=%b Entrada=%b cycle %0d",
                        Controle, parity_err, frame_err, code_err, Entrada, cyc,
                        e.c, e.pe, e.fe, e.ce, e.data, e.due);
            end
         end
      end
   endtask

   task automatic send_bit(input logic b, input int gap);
      serial_in = b;
      bit_en    = 1'b1;
      step();
      bit_en    = 1'b0;
      repeat (gap) step();
   endtask

   task automatic send_frame(input logic [6:0] d, input logic p, input logic stop, input int gap);
      exp_t e;
      logic ok;
      send_bit(1'b0, gap);
      for (int i = 6; i >= 0; i--) send_bit(d[i], gap);
      send_bit(p, gap);
      ok   = (((^d) ^ p) == 1'b1);
      e.c  = 1'b0;
      e.pe = 1'b0;
      e.fe = 1'b0;
      e.ce = 1'b0;
      if (stop) begin
         if (ok && model_code_ok(d)) begin
            e.c = 1'b1;
            model_entrada = d;
         end else if (ok) begin
            e.ce = 1'b1;
         end else begin
            e.pe = 1'b1;
         end
      end else begin
         e.fe = 1'b1;
         e.pe = !ok;
      end
      e.data = model_entrada;
      e.due  = cyc + 1;
      sb.push_back(e);
      send_bit(stop, gap);
   endtask

   task automatic drain(input string name);
      serial_in = 1'b1;
      bit_en    = 1'b0;
      repeat (4) step();
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL %s_missing_pulse: %0d expected pulses not seen, required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset();
      Reset     = 1'b0;
      bit_en    = 1'b0;
      serial_in = 1'b1;
      repeat (3) step();
      compared++;
      if ({Entrada, Controle, parity_err, frame_err, code_err, busy} !== 12'd0) begin
         mismatched++;
         $display("FAIL reset_state: got Entrada=%b C=%b PE=%b FE=%b CE=%b busy=%b, required all 0",
                  Entrada, Controle, parity_err, frame_err, code_err, busy);
      end
      Reset = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_basic();
      send_frame(7'b1100000, 1'b1, 1'b1, 0);
      drain("basic");
      compared++;
      if (Entrada !== 7'b1100000 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL basic_entrada: got %b busy=%b, required 1100000 busy=0", Entrada, busy);
      end
   endtask

   task automatic test_slow_bit_en();
      send_frame(7'b1111100, 1'b0, 1'b1, 2);
      drain("slow");
      compared++;
      if (Entrada !== 7'b1111100) begin
         mismatched++;
         $display("FAIL slow_entrada: got %b, required 1111100", Entrada);
      end
   endtask

   task automatic test_parity_err();
      send_frame(7'b1000100, 1'b0, 1'b1, 0);
      drain("parity");
      compared++;
      if (Entrada !== 7'b1111100) begin
         mismatched++;
         $display("FAIL parity_hold: got %b, required 1111100", Entrada);
      end
   endtask

   task automatic test_break();
      send_frame(7'b1011010, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         send_bit(1'b0, 0);
         compared++;
         if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL break_busy: held-low bit %0d got busy=%b, required 1", i, busy);
         end
      end
      send_bit(1'b1, 0);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL break_release: got busy=%b, required 0", busy);
      end
      for (int i = 0; i < 2; i++) begin
         send_bit(1'b1, 0);
         compared++;
         if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL break_no_spurious: got busy=%b, required 0", busy);
         end
      end
      drain("break");
   endtask

   task automatic test_reset_mid_frame();
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("FAIL midframe_busy: got busy=%b, required 1", busy);
      end
      #2 Reset = 1'b0;
      #1;
      compared++;
      if ({Entrada, Controle, parity_err, frame_err, code_err, busy} !== 12'd0) begin
         mismatched++;
         $display("FAIL midframe_reset: got Entrada=%b C=%b PE=%b FE=%b CE=%b busy=%b, required all 0",
                  Entrada, Controle, parity_err, frame_err, code_err, busy);
      end
      model_entrada = 7'd0;
      prev_entrada  = 7'd0;
      step();
      Reset = 1'b1;
      serial_in = 1'b1;
      step();
      send_frame(7'b1101110, 1'b0, 1'b1, 0);
      drain("midframe");
      compared++;
      if (Entrada !== 7'b1101110) begin
         mismatched++;
         $display("FAIL midframe_recover: got %b, required 1101110", Entrada);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(7'b1001001, 1'b0, 1'b1, 0);
      send_frame(7'b1110101, 1'b0, 1'b1, 0);
      drain("b2b");
      compared++;
      if (Entrada !== 7'b1110101) begin
         mismatched++;
         $display("FAIL b2b_entrada: got %b, required 1110101", Entrada);
      end
   endtask

   task automatic test_filter();
      send_frame(7'b1010101, 1'b1, 1'b1, 0);
      drain("filter");
      compared++;
      if (Entrada !== model_entrada) begin
         mismatched++;
         $display("FAIL filter_entrada: got %b, required %b", Entrada, model_entrada);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow_bit_en();
      test_parity_err();
      test_break();
      test_reset_mid_frame();
      test_back_to_back();
      test_filter();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
